lt24_redraw_scheduler: RTL and testbench

- Replaces the free-running full-screen raster with request-driven region redraws on the LT24 pixel interface.
- Queues redraw requests from game logic and arbitrates them: full frame, top banner, bottom banner, individual board squares.
- For each region it walks the region's pixels, issues a coordinate to the sprite-index/ROM lookup, waits out the ROM latency, and writes the pixel to LT24Display using the pixelWrite/pixelReady handshake.

---
 rtl/lt24_redraw_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_lt24_redraw_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_redraw_scheduler.sv
// Request-driven region redraw scheduler for the LT24 pixel interface.
// Optional macro REDRAW_REGION_COUNT_EN adds a saturating regionCount output.
module lt24_redraw_scheduler #(
  parameter int LCD_WIDTH     = 240,
  parameter int LCD_HEIGHT    = 320,
  parameter int BANNER_HEIGHT = 40,
  parameter int SQUARE_SIZE   = 30,
  parameter int ROM_LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqFrame,
  input  logic        reqTopBanner,
  input  logic        reqBotBanner,
  input  logic        reqSquare,
  input  logic [5:0]  squareIdx,
  output logic [7:0]  lookupX,
  output logic [8:0]  lookupY,
  input  logic [15:0] romData,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic        busy,
  output logic        regionDone,
  output logic [2:0]  doneId
`ifdef REDRAW_REGION_COUNT_EN
  ,
  output logic [15:0] regionCount
`endif
);

  localparam logic [7:0] X_MAX     = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] Y_MAX     = 9'(LCD_HEIGHT - 1);
  localparam logic [8:0] TOP_Y1    = 9'(BANNER_HEIGHT - 1);
  localparam logic [8:0] BOT_Y0    = 9'(LCD_HEIGHT - BANNER_HEIGHT);
  localparam logic [8:0] BOARD_Y0  = 9'(BANNER_HEIGHT);
  localparam logic [7:0] SQ_SIZE_X = 8'(SQUARE_SIZE);
  localparam logic [8:0] SQ_SIZE_Y = 9'(SQUARE_SIZE);
  localparam logic [7:0] SQ_EXT_X  = 8'(SQUARE_SIZE - 1);
  localparam logic [8:0] SQ_EXT_Y  = 9'(SQUARE_SIZE - 1);
  localparam logic [1:0] WAIT_LAST = 2'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, WRITE, DONE
  } state_e;

  typedef enum logic [2:0] {
    REG_FRAME  = 3'd0,
    REG_TOP    = 3'd1,
    REG_BOT    = 3'd2,
    REG_SQUARE = 3'd3
  } region_e;

  state_e      state_q, state_d;
  region_e     regionId_q, regionId_d;
  logic        framePend_q, framePend_d;
  logic        topPend_q, topPend_d;
  logic        botPend_q, botPend_d;
  logic [63:0] sqPend_q, sqPend_d;
  logic [7:0]  curX_q, curX_d, x0_q, x0_d, x1_q, x1_d;
  logic [8:0]  curY_q, curY_d, y1_q, y1_d;
  logic [1:0]  waitCnt_q, waitCnt_d;
  logic [7:0]  xAddr_q, xAddr_d;
  logic [8:0]  yAddr_q, yAddr_d;
  logic [15:0] pixelData_q, pixelData_d;
  logic        pixelWrite_q, pixelWrite_d;
  logic        regionDone_q, regionDone_d;
  logic [2:0]  doneId_q, doneId_d;

  logic [5:0]  lowSq;
  logic [7:0]  sqX0;
  logic [8:0]  sqY0;

  // Lowest-index pending square and its corner, via constant multiplies.
  always_comb begin
    lowSq = '0;
    for (int i = 63; i >= 0; i--) begin
      if (sqPend_q[i]) lowSq = 6'(i);
    end
    sqX0 = 8'(lowSq[2:0]) * SQ_SIZE_X;
    sqY0 = BOARD_Y0 + 9'(lowSq[5:3]) * SQ_SIZE_Y;
  end

  always_comb begin
    state_d      = state_q;
    regionId_d   = regionId_q;
    framePend_d  = framePend_q;
    topPend_d    = topPend_q;
    botPend_d    = botPend_q;
    sqPend_d     = sqPend_q;
    curX_d       = curX_q;
    curY_d       = curY_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    waitCnt_d    = waitCnt_q;
    xAddr_d      = xAddr_q;
    yAddr_d      = yAddr_q;
    pixelData_d  = pixelData_q;
    pixelWrite_d = pixelWrite_q;
    regionDone_d = 1'b0;
    doneId_d     = doneId_q;

    unique case (state_q)
      IDLE: begin
        if (framePend_q) begin
          framePend_d = 1'b0;
          topPend_d   = 1'b0;
          botPend_d   = 1'b0;
          sqPend_d    = '0;
          regionId_d  = REG_FRAME;
          x0_d = '0;  x1_d = X_MAX;  curX_d = '0;
          curY_d = '0;  y1_d = Y_MAX;
          state_d = FETCH;
        end else if (topPend_q) begin
          topPend_d  = 1'b0;
          regionId_d = REG_TOP;
          x0_d = '0;  x1_d = X_MAX;  curX_d = '0;
          curY_d = '0;  y1_d = TOP_Y1;
          state_d = FETCH;
        end else if (botPend_q) begin
          botPend_d  = 1'b0;
          regionId_d = REG_BOT;
          x0_d = '0;  x1_d = X_MAX;  curX_d = '0;
          curY_d = BOT_Y0;  y1_d = Y_MAX;
          state_d = FETCH;
        end else if (|sqPend_q) begin
          sqPend_d[lowSq] = 1'b0;
          regionId_d = REG_SQUARE;
          x0_d = sqX0;  x1_d = sqX0 + SQ_EXT_X;  curX_d = sqX0;
          curY_d = sqY0;  y1_d = sqY0 + SQ_EXT_Y;
          state_d = FETCH;
        end
      end
      FETCH: begin
        waitCnt_d = WAIT_LAST;
        state_d   = WAIT;
      end
      WAIT: begin
        if (waitCnt_q == 2'd0) begin
          pixelData_d  = romData;
          xAddr_d      = curX_q;
          yAddr_d      = curY_q;
          pixelWrite_d = 1'b1;
          state_d      = WRITE;
        end else begin
          waitCnt_d = waitCnt_q - 2'd1;
        end
      end
      WRITE: begin
        if (pixelReady) begin
          pixelWrite_d = 1'b0;
          if (curX_q == x1_q && curY_q == y1_q) begin
            regionDone_d = 1'b1;
            doneId_d     = regionId_q;
            state_d      = DONE;
          end else begin
            state_d = FETCH;
            if (curX_q == x1_q) begin
              curX_d = x0_q;
              curY_d = curY_q + 9'd1;
            end else begin
              curX_d = curX_q + 8'd1;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // New requests land after grant clears, so a request for the region being
    // started or drawn always schedules one more pass.
    if (reqFrame)     framePend_d = 1'b1;
    if (reqTopBanner) topPend_d   = 1'b1;
    if (reqBotBanner) botPend_d   = 1'b1;
    if (reqSquare)    sqPend_d[squareIdx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      regionId_q   <= REG_FRAME;
      framePend_q  <= 1'b1;
      topPend_q    <= 1'b0;
      botPend_q    <= 1'b0;
      sqPend_q     <= '0;
      curX_q       <= '0;
      curY_q       <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      waitCnt_q    <= '0;
      xAddr_q      <= '0;
      yAddr_q      <= '0;
      pixelData_q  <= '0;
      pixelWrite_q <= 1'b0;
      regionDone_q <= 1'b0;
      doneId_q     <= '0;
    end else begin
      state_q      <= state_d;
      regionId_q   <= regionId_d;
      framePend_q  <= framePend_d;
      topPend_q    <= topPend_d;
      botPend_q    <= botPend_d;
      sqPend_q     <= sqPend_d;
      curX_q       <= curX_d;
      curY_q       <= curY_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      waitCnt_q    <= waitCnt_d;
      xAddr_q      <= xAddr_d;
      yAddr_q      <= yAddr_d;
      pixelData_q  <= pixelData_d;
      pixelWrite_q <= pixelWrite_d;
      regionDone_q <= regionDone_d;
      doneId_q     <= doneId_d;
    end
  end

  assign lookupX    = curX_q;
  assign lookupY    = curY_q;
  assign xAddr      = xAddr_q;
  assign yAddr      = yAddr_q;
  assign pixelData  = pixelData_q;
  assign pixelWrite = pixelWrite_q;
  assign busy       = (state_q != IDLE);
  assign regionDone = regionDone_q;
  assign doneId     = doneId_q;

`ifdef REDRAW_REGION_COUNT_EN
  logic [15:0] regionCount_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      regionCount_q <= '0;
    end else if (regionDone_q && regionCount_q != 16'hFFFF) begin
      regionCount_q <= regionCount_q + 16'd1;
    end
  end

  assign regionCount = regionCount_q;
`endif

endmodule

// File: tb/tb_lt24_redraw_scheduler.sv
// Bench for lt24_redraw_scheduler on a reduced screen geometry so full frames stay short.
// Compares every accepted pixel and every regionDone against a region-list model.
module tb_lt24_redraw_scheduler;

   localparam int W   = 24;
   localparam int H   = 32;
   localparam int BH  = 4;
   localparam int SQ  = 3;
   localparam int LAT = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reqFrame = 1'b0;
   logic        reqTopBanner = 1'b0;
   logic        reqBotBanner = 1'b0;
   logic        reqSquare = 1'b0;
   logic [5:0]  squareIdx = '0;
   logic [7:0]  lookupX;
   logic [8:0]  lookupY;
   logic [15:0] romData;
   logic [7:0]  xAddr;
   logic [8:0]  yAddr;
   logic [15:0] pixelData;
   logic        pixelWrite;
   logic        pixelReady = 1'b1;
   logic        busy;
   logic        regionDone;
   logic [2:0]  doneId;
`ifdef REDRAW_REGION_COUNT_EN
   logic [15:0] regionCount;
`endif

   int testsRun = 0;
   int failCount = 0;

   lt24_redraw_scheduler #(
      .LCD_WIDTH(W), .LCD_HEIGHT(H), .BANNER_HEIGHT(BH),
      .SQUARE_SIZE(SQ), .ROM_LATENCY(LAT)
   ) dut (
      .clock(clock), .reset(reset),
      .reqFrame(reqFrame), .reqTopBanner(reqTopBanner), .reqBotBanner(reqBotBanner),
      .reqSquare(reqSquare), .squareIdx(squareIdx),
      .lookupX(lookupX), .lookupY(lookupY), .romData(romData),
      .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
      .pixelWrite(pixelWrite), .pixelReady(pixelReady),
      .busy(busy), .regionDone(regionDone), .doneId(doneId)
`ifdef REDRAW_REGION_COUNT_EN
      , .regionCount(regionCount)
`endif
   );

   always #5 clock = ~clock;

   // Sprite ROM stand-in: a per-pixel colour delivered LAT cycles after the lookup.
   function automatic logic [15:0] pixColour(input logic [7:0] x, input logic [8:0] y);
      return {y[7:0], x} ^ 16'h5A3C;
   endfunction

   logic [15:0] romPipe [LAT];
   always @(posedge clock) begin
      romPipe[0] <= pixColour(lookupX, lookupY);
      for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
   end
   assign romData = romPipe[LAT-1];

   int cycleCnt = 0;
   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   // Monitor: drives pixelReady for the coming edge, then records transfers,
   // completions and any change on the write bus while a write is stalled.
   bit          readyRandom = 1'b0;
   logic        readyFixed = 1'b1;
   int          stableViol = 0;
   int          totalDones = 0;
   logic        holdPrev = 1'b0;
   logic [33:0] prevVec = '0;
   logic [7:0]  obsX[$];
   logic [8:0]  obsY[$];
   logic [15:0] obsD[$];
   int          obsT[$];
   logic [2:0]  doneQ[$];

   always @(negedge clock) begin
      pixelReady = readyRandom ? 1'($urandom_range(0, 1)) : readyFixed;
      if (reset) begin
         holdPrev = 1'b0;
      end else begin
         if (holdPrev && {pixelWrite, xAddr, yAddr, pixelData} !== prevVec) stableViol++;
         if (pixelWrite && pixelReady) begin
            obsX.push_back(xAddr);
            obsY.push_back(yAddr);
            obsD.push_back(pixelData);
            obsT.push_back(cycleCnt);
         end
         if (regionDone) begin
            doneQ.push_back(doneId);
            totalDones++;
         end
         holdPrev = pixelWrite && !pixelReady;
         prevVec = {pixelWrite, xAddr, yAddr, pixelData};
      end
   end

   logic [7:0] expX[$];
   logic [8:0] expY[$];
   logic [2:0] expDone[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic f, input logic t, input logic b,
                                input logic s, input logic [5:0] idx);
      @(negedge clock);
      reqFrame = f; reqTopBanner = t; reqBotBanner = b; reqSquare = s; squareIdx = idx;
      @(negedge clock);
      reqFrame = 1'b0; reqTopBanner = 1'b0; reqBotBanner = 1'b0; reqSquare = 1'b0;
   endtask

   // Appends one region's pixels in raster order plus its completion id.
   task automatic expectRegion(input int id, input int sq);
      int x0, x1, y0, y1;
      case (id)
         0: begin x0 = 0; x1 = W-1; y0 = 0;    y1 = H-1;  end
         1: begin x0 = 0; x1 = W-1; y0 = 0;    y1 = BH-1; end
         2: begin x0 = 0; x1 = W-1; y0 = H-BH; y1 = H-1;  end
         default: begin
            x0 = (sq % 8) * SQ; x1 = x0 + SQ - 1;
            y0 = BH + (sq / 8) * SQ; y1 = y0 + SQ - 1;
         end
      endcase
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            expX.push_back(8'(x));
            expY.push_back(9'(y));
         end
      expDone.push_back(3'(id));
   endtask

   task automatic waitDones(input int n, input int budget);
      int c = 0;
      while (doneQ.size() < n && c < budget) begin
         @(negedge clock);
         c++;
      end
      if (doneQ.size() < n) checkOutput("region completion timeout", doneQ.size(), n);
      repeat (3) @(negedge clock);
   endtask

   task automatic verifyStream(input string tag);
      int mism = 0;
      checkOutput({tag, " write count"}, obsX.size(), expX.size());
      for (int i = 0; i < obsX.size() && i < expX.size(); i++)
         if (obsX[i] !== expX[i] || obsY[i] !== expY[i] || obsD[i] !== pixColour(expX[i], expY[i]))
            mism++;
      checkOutput({tag, " pixel mismatches"}, mism, 0);
      checkOutput({tag, " region count"}, doneQ.size(), expDone.size());
      mism = 0;
      for (int i = 0; i < doneQ.size() && i < expDone.size(); i++)
         if (doneQ[i] !== expDone[i]) mism++;
      checkOutput({tag, " doneId mismatches"}, mism, 0);
      checkOutput({tag, " stalled bus changes"}, stableViol, 0);
      checkOutput({tag, " busy after"}, 32'(busy), 0);
      obsX.delete(); obsY.delete(); obsD.delete(); obsT.delete();
      doneQ.delete(); expX.delete(); expY.delete(); expDone.delete();
      stableViol = 0;
   endtask

   initial begin
      int bad;
      int c;
      bit f, t, b;
      bit [63:0] sqSet;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("reset pixelWrite", 32'(pixelWrite), 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset regionDone", 32'(regionDone), 0);
      checkOutput("reset doneId", 32'(doneId), 0);
      checkOutput("reset xAddr", 32'(xAddr), 0);
      checkOutput("reset yAddr", 32'(yAddr), 0);
      checkOutput("reset pixelData", 32'(pixelData), 0);
      checkOutput("reset lookup", 32'({lookupY, lookupX}), 0);
`ifdef REDRAW_REGION_COUNT_EN
      checkOutput("reset regionCount", 32'(regionCount), 0);
`endif

      // Power-up frame with pixelReady high: raster order and fixed write spacing
      reset = 1'b0;
      expectRegion(0, 0);
      waitDones(1, 20000);
      bad = 0;
      for (int i = 1; i < obsT.size(); i++)
         if (obsT[i] - obsT[i-1] != LAT + 2) bad++;
      checkOutput("frame write gap", bad, 0);
      verifyStream("power-up frame");

      // Squares queued behind a banner are served lowest index first
      readyRandom = 1'b1;
      applyStimulus(0, 1, 0, 0, 6'd0);
      applyStimulus(0, 0, 0, 1, 6'd63);
      applyStimulus(0, 0, 0, 1, 6'd9);
      expectRegion(1, 0);
      expectRegion(3, 9);
      expectRegion(3, 63);
      waitDones(3, 20000);
      verifyStream("squares 9 and 63");

      // Simultaneous requests: top, bottom, then square 0
      applyStimulus(0, 1, 1, 1, 6'd0);
      expectRegion(1, 0);
      expectRegion(2, 0);
      expectRegion(3, 0);
      waitDones(3, 20000);
      verifyStream("banner priority");

      // Re-request of the square being drawn gives one extra pass
      applyStimulus(0, 0, 0, 1, 6'd5);
      c = 0;
      while (obsX.size() < 3 && c < 500) begin @(negedge clock); c++; end
      applyStimulus(0, 0, 0, 1, 6'd5);
      expectRegion(3, 5);
      expectRegion(3, 5);
      waitDones(2, 20000);
      verifyStream("square 5 redraw");

      // Random request bursts issued while a top banner is being drawn
      for (int r = 0; r < 3; r++) begin
         applyStimulus(0, 1, 0, 0, 6'd0);
         expectRegion(1, 0);
         f = 0; t = 0; b = 0; sqSet = '0;
         repeat (6) begin
            int kind, idx;
            kind = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(0, 63));
            case (kind)
               0: begin applyStimulus(1, 0, 0, 0, 6'd0); f = 1; end
               1: begin applyStimulus(0, 1, 0, 0, 6'd0); t = 1; end
               2: begin applyStimulus(0, 0, 1, 0, 6'd0); b = 1; end
               default: begin applyStimulus(0, 0, 0, 1, 6'(idx)); sqSet[idx] = 1'b1; end
            endcase
         end
         if (f) expectRegion(0, 0);
         else begin
            if (t) expectRegion(1, 0);
            if (b) expectRegion(2, 0);
            for (int i = 0; i < 64; i++) if (sqSet[i]) expectRegion(3, i);
         end
         waitDones(expDone.size(), 40000);
         verifyStream($sformatf("random burst %0d", r));
      end

`ifdef REDRAW_REGION_COUNT_EN
      checkOutput("regionCount tally", 32'(regionCount), totalDones);
`endif

      // Reset while the 100th pixel of a frame is stalled in its write
      readyRandom = 1'b0;
      readyFixed = 1'b1;
      applyStimulus(1, 0, 0, 0, 6'd0);
      c = 0;
      while (obsX.size() < 99 && c < 2000) begin @(negedge clock); c++; end
      readyFixed = 1'b0;
      c = 0;
      while (!pixelWrite && c < 100) begin @(negedge clock); c++; end
      checkOutput("stalled on pixel 100", 32'(pixelWrite), 1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abort pixelWrite", 32'(pixelWrite), 0);
      checkOutput("abort busy", 32'(busy), 0);
      checkOutput("writes before abort", obsX.size(), 99);
      checkOutput("no regionDone on abort", doneQ.size(), 0);
`ifdef REDRAW_REGION_COUNT_EN
      checkOutput("abort regionCount", 32'(regionCount), 0);
`endif
      obsX.delete(); obsY.delete(); obsD.delete(); obsT.delete(); doneQ.delete();
      stableViol = 0;
      totalDones = 0;
      readyFixed = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      expectRegion(0, 0);
      waitDones(1, 20000);
      verifyStream("frame after reset");
`ifdef REDRAW_REGION_COUNT_EN
      checkOutput("regionCount after frame", 32'(regionCount), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
